// File: rtl/microp_pkg.sv
// Shared types for the 8-bit microP sequencer: opcodes, FSM states,
// instruction field layout and immediate sign-extension helpers.
package microp_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_LW  = 2'b01,
        OP_SW  = 2'b10,
        OP_JMP = 2'b11
    } opcodeT;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } seqStateT;

    typedef struct packed {
        opcodeT     op;
        logic [1:0] rs;
        logic [1:0] rt;
        logic [1:0] rd;
    } instrT;

    function automatic logic [1:0] imm2Of(instrT i);
        return i.rd;
    endfunction

    function automatic logic [5:0] imm6Of(instrT i);
        return {i.rs, i.rt, i.rd};
    endfunction

    // Results are 16 bits wide; callers size-cast down to their address width.
    function automatic logic [15:0] sext2(logic [1:0] imm);
        return {{14{imm[1]}}, imm};
    endfunction

    function automatic logic [15:0] sext6(logic [5:0] imm);
        return {{10{imm[5]}}, imm};
    endfunction

endpackage

// File: rtl/seq_pc_unit.sv
// Program counter for the microP sequencer: holds pc, advances by one or by
// one plus a signed 6-bit jump offset; wraps modulo 2^PC_W.
module seq_pc_unit
    import microp_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            incEn,
    input  logic            jmpEn,
    input  logic [5:0]      imm6,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pcNext;

    always_comb begin
        pcNext = pc + PC_W'(1);
        if (jmpEn) pcNext = pc + PC_W'(1) + PC_W'(sext6(imm6));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              pc <= '0;
        else if (incEn || jmpEn) pc <= pcNext;
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute/writeback sequencer for the 8-bit microP, driving the
// 4x8 register file. Define SEQ_RETIRE_CNT_EN to add the retire_cnt output.
module instr_sequencer
    import microp_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int DMEM_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [PC_W-1:0]   imem_addr,
    output logic              imem_req,
    input  logic              imem_valid,
    input  logic [7:0]        imem_data,
    output logic              RegWrite,
    output logic [1:0]        Read1,
    output logic [1:0]        Read2,
    output logic [1:0]        WriteR,
    output logic [7:0]        WriteD,
    input  logic [7:0]        ReadD1,
    input  logic [7:0]        ReadD2,
    output logic [DMEM_W-1:0] dmem_addr,
    output logic              dmem_we,
    output logic [7:0]        dmem_wdata,
    output logic              dmem_re,
    input  logic              dmem_valid,
    input  logic [7:0]        dmem_rdata,
    output logic [PC_W-1:0]   pc
`ifdef SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0]       retire_cnt
`endif
);

    seqStateT          state, nextState;
    instrT             ir;
    logic [DATA_W-1:0] op1, op2, result;
    logic              armed;
    logic              incEn, jmpEn;
    logic [DMEM_W-1:0] memAddr;

    seq_pc_unit #(.PC_W(PC_W)) uPc (
        .clk   (clk),
        .rst_n (rst_n),
        .incEn (incEn),
        .jmpEn (jmpEn),
        .imm6  (imm6Of(ir)),
        .pc    (pc)
    );

    assign imem_addr = pc;
    assign Read1     = ir.rs;
    assign Read2     = ir.rt;
    assign memAddr   = DMEM_W'(op1) + DMEM_W'(sext2(imm2Of(ir)));

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        nextState  = state;
        imem_req   = 1'b0;
        RegWrite   = 1'b0;
        WriteR     = '0;
        WriteD     = '0;
        dmem_we    = 1'b0;
        dmem_re    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        incEn      = 1'b0;
        jmpEn      = 1'b0;
        case (state)
            FETCH: begin
                imem_req = armed;
                if (armed && imem_valid) nextState = DECODE;
            end
            DECODE: nextState = EXEC;
            EXEC: begin
                case (ir.op)
                    OP_ADD: nextState = WB;
                    OP_LW:  nextState = MEM;
                    OP_SW: begin
                        dmem_we    = 1'b1;
                        dmem_addr  = memAddr;
                        dmem_wdata = op2;
                        incEn      = 1'b1;
                        nextState  = FETCH;
                    end
                    OP_JMP: begin
                        jmpEn     = 1'b1;
                        nextState = FETCH;
                    end
                    default: nextState = FETCH;
                endcase
            end
            MEM: begin
                dmem_re   = 1'b1;
                dmem_addr = memAddr;
                if (dmem_valid) nextState = WB;
            end
            WB: begin
                RegWrite  = 1'b1;
                WriteR    = (ir.op == OP_LW) ? ir.rt : ir.rd;
                WriteD    = result;
                incEn     = 1'b1;
                nextState = FETCH;
            end
            default: nextState = FETCH;
        endcase
    end

    // armed keeps imem_req low during reset; the first request follows release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FETCH;
            armed  <= 1'b0;
            ir     <= '0;
            op1    <= '0;
            op2    <= '0;
            result <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state <= nextState;
            armed <= 1'b1;
            if (state == FETCH && armed && imem_valid) ir <= instrT'(imem_data);
            if (state == DECODE) begin
                op1 <= ReadD1;
                op2 <= ReadD2;
            end
            if (state == EXEC && ir.op == OP_ADD) result <= op1 + op2;
            if (state == MEM && dmem_valid)       result <= dmem_rdata;
        end
    end

`ifdef SEQ_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retire_cnt <= '0;
        else if (nextState == FETCH && (state == WB || state == EXEC))
            retire_cnt <= retire_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: behavioural imem/dmem/register-file
// models with programmable latency and a register-write scoreboard.
module tb_instr_sequencer;

    logic       clk, rst_n;
    logic [7:0] imem_addr, dmem_addr, pc;
    logic       imem_req, imem_valid, RegWrite, dmem_we, dmem_re, dmem_valid;
    logic [7:0] imem_data, WriteD, ReadD1, ReadD2, dmem_wdata, dmem_rdata;
    logic [1:0] Read1, Read2, WriteR;
`ifdef SEQ_RETIRE_CNT_EN
    logic [15:0] retire_cnt;
`endif

    logic [7:0] imem [256];
    logic [7:0] dm   [256];
    logic [7:0] rf   [4];

    typedef struct packed {
        logic [1:0] r;
        logic [7:0] d;
    } wrT;
    wrT expQ[$];
    wrT obsQ[$];

    int vectors = 0, miscompares = 0;
    int imemLat = 0, dmemLat = 0, imemWait = 0, dmemWait = 0;
    logic imemPrev = 1'b0, dmemPrev = 1'b0;
    int weCnt = 0;
    logic [7:0] lastWeAddr = '0, lastWeData = '0;

    assign ReadD1 = rf[Read1];
    assign ReadD2 = rf[Read2];

    instr_sequencer #(.PC_W(8), .DMEM_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .RegWrite   (RegWrite),
        .Read1      (Read1),
        .Read2      (Read2),
        .WriteR     (WriteR),
        .WriteD     (WriteD),
        .ReadD1     (ReadD1),
        .ReadD2     (ReadD2),
        .dmem_addr  (dmem_addr),
        .dmem_we    (dmem_we),
        .dmem_wdata (dmem_wdata),
        .dmem_re    (dmem_re),
        .dmem_valid (dmem_valid),
        .dmem_rdata (dmem_rdata),
        .pc         (pc)
`ifdef SEQ_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic updMem();
        imem_valid = imem_req && (imemWait >= imemLat);
        imem_data  = imem_valid ? imem[imem_addr] : 8'h00;
        dmem_valid = dmem_re && (dmemWait >= dmemLat);
        dmem_rdata = dmem_valid ? dm[dmem_addr] : 8'h00;
    endtask

    // One clock: sample strobes 1 time unit after the edge, then update models.
    task automatic tick();
        @(posedge clk);
        #1;
        if (RegWrite) begin
            obsQ.push_back('{r: WriteR, d: WriteD});
            rf[WriteR] = WriteD;
        end
        if (dmem_we) begin
            dm[dmem_addr] = dmem_wdata;
            weCnt++;
            lastWeAddr = dmem_addr;
            lastWeData = dmem_wdata;
        end
        imemWait = (imem_req && imemPrev) ? imemWait + 1 : 0;
        dmemWait = (dmem_re && dmemPrev) ? dmemWait + 1 : 0;
        imemPrev = imem_req;
        dmemPrev = dmem_re;
        updMem();
    endtask

    // Runs from a FETCH cycle to the start of the next FETCH, counting cycles.
    task automatic runInstr(string tag, output int cyc);
        int n = 0;
        while (imem_req === 1'b1 && n < 300) begin tick(); n++; end
        while (imem_req !== 1'b1 && n < 300) begin tick(); n++; end
        check({tag, "-timeout"}, 32'(n < 300), 32'd1);
        cyc = n;
    endtask

    task automatic scoreCheck(string tag);
        wrT e, o;
        check({tag, "-wrcount"}, obsQ.size(), expQ.size());
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            check({tag, "-wr"}, 32'(o), 32'(e));
        end
        expQ.delete();
        obsQ.delete();
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        imem_valid = 1'b0; imem_data = '0; dmem_valid = 1'b0; dmem_rdata = '0;
        for (int i = 0; i < 256; i++) begin imem[i] = 8'h00; dm[i] = 8'h00; end
        rf[0] = 8'hAA; rf[1] = 8'hFF; rf[2] = 8'h00; rf[3] = 8'h81;
        imem[8'h00] = 8'b00_00_01_10;  // ADD r2 = r0 + r1
        imem[8'h01] = 8'b10_00_01_01;  // SW  M[r0+1] = r1
        imem[8'h02] = 8'b01_00_10_01;  // LW  r2 = M[r0+1]
        imem[8'h03] = 8'b11_111010;    // JMP -6 -> FE
        imem[8'hFE] = 8'b11_111110;    // JMP -2 -> FD
        imem[8'hFD] = 8'b11_000001;    // JMP +1 -> FF
        imem[8'hFF] = 8'b11_000000;    // JMP +0 -> 00 (wrap)

        repeat (3) tick();
        check("reset-outputs", {pc, imem_req, dmem_re, dmem_we, RegWrite, WriteR, WriteD, dmem_addr}, 32'd0);
        check("reset-reads", {Read1, Read2, imem_addr}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("first-fetch-req", {imem_req, pc}, {1'b1, 8'h00});

        // ADD: AA + FF = A9 (carry dropped) into r2
        expQ.push_back('{r: 2'd2, d: 8'hA9});
        runInstr("add", cyc);
        check("add-latency", cyc, 4);
        scoreCheck("add");
        check("add-pc", pc, 8'h01);

        // SW: M[10+1] = 3C
        rf[0] = 8'h10; rf[1] = 8'h3C;
        runInstr("sw", cyc);
        check("sw-latency", cyc, 3);
        check("sw-we-pulses", weCnt, 1);
        check("sw-addr", lastWeAddr, 8'h11);
        check("sw-wdata", lastWeData, 8'h3C);
        scoreCheck("sw");
        check("sw-pc", pc, 8'h02);

        // LW with a 3-cycle data-memory wait
        dmemLat = 3;
        expQ.push_back('{r: 2'd2, d: 8'h3C});
        runInstr("lw", cyc);
        scoreCheck("lw");
        check("lw-pc", pc, 8'h03);
        dmemLat = 0;

        // Jumps, including the FF -> 00 wrap
        runInstr("jmp1", cyc);
        check("jmp-latency", cyc, 3);
        check("jmp1-pc", pc, 8'hFE);
`ifdef SEQ_RETIRE_CNT_EN
        check("retire-cnt-4", retire_cnt, 16'd4);
`endif
        runInstr("jmp2", cyc);
        check("jmp-neg2-pc", pc, 8'hFD);
        runInstr("jmp3", cyc);
        check("jmp-pos1-pc", pc, 8'hFF);
        runInstr("jmp4", cyc);
        check("jmp-wrap-pc", pc, 8'h00);
        check("jmp-we-pulses", weCnt, 1);
        scoreCheck("jmp");

        // Fetch stall: instruction arrives after 5 idle cycles
        imemLat = 5;
        updMem();
        expQ.push_back('{r: 2'd2, d: 8'h4C});
        for (int i = 0; i < 5; i++) begin
            check("stall-hold", {imem_req, RegWrite, dmem_we, dmem_re, pc}, {4'b1000, 8'h00});
            tick();
        end
        runInstr("stall-add", cyc);
        scoreCheck("stall-add");
        check("stall-pc", pc, 8'h01);
        imemLat = 0;

        // rs == rt == rd: r3 = 81 + 81 = 02
        imem[8'h01] = 8'b00_11_11_11;
        updMem();
        expQ.push_back('{r: 2'd3, d: 8'h02});
        runInstr("self-add", cyc);
        scoreCheck("self-add");
        check("self-add-pc", pc, 8'h02);

        // Reset while LW waits in MEM
        dmemLat = 100;
        cyc = 0;
        while (dmem_re !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        check("mem-reached", 32'(cyc < 20), 32'd1);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("midreset-async", {pc, imem_req, dmem_re, dmem_we, RegWrite, dmem_addr}, 32'd0);
        tick();
        check("midreset-held", {pc, imem_req, dmem_re, dmem_we, RegWrite}, 32'd0);
        rst_n = 1'b1;
        dmemLat = 0;
        tick();
        check("midreset-fetch", {imem_req, pc}, {1'b1, 8'h00});
        scoreCheck("midreset");
        expQ.push_back('{r: 2'd2, d: 8'h4C});
        runInstr("post-reset-add", cyc);
        scoreCheck("post-reset-add");
        check("post-reset-pc", pc, 8'h01);
`ifdef SEQ_RETIRE_CNT_EN
        check("retire-cnt-after-reset", retire_cnt, 16'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
